// File: rtl/booth_div_32x16_seq.sv
// booth_div_32x16_seq: iterative radix-2 restoring divider, 32-bit dividend by 16-bit divisor.
// Produces one quotient bit per cycle and applies the signs in a final fix-up cycle.
module booth_div_32x16_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_in,
    output logic        ready,
    input  logic [31:0] n,
    input  logic [15:0] d,
    input  logic [1:0]  sm,
    output logic [31:0] q,
    output logic [16:0] r,
    output logic        div0,
    output logic        ovf,
    output logic        v_out
);
    typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_ITER, ST_FIX} state_t;

    state_t      state_q, state_d;
    logic [31:0] n_q, n_d, dvd_q, dvd_d, q_q, q_d;
    logic [15:0] d_q, d_d, dmag_q, dmag_d;
    logic [1:0]  sm_q, sm_d;
    logic [16:0] rem_q, rem_d, r_q, r_d, rs;
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic        div0_q, div0_d, ovf_q, ovf_d, v_out_q, v_out_d;
    logic [17:0] sh, diff;
    logic [31:0] qs;
    logic        n_neg, d_neg;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        sm_d    = sm_q;
        dvd_d   = dvd_q;
        dmag_d  = dmag_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        v_out_d = 1'b0;
        n_neg   = sm_q[1] & n_q[31];
        d_neg   = sm_q[0] & d_q[15];
        // 18-bit trial so the borrow is visible even when the shifted remainder uses all 17 bits
        sh      = {rem_q, dvd_q[31]};
        diff    = sh - {2'b00, dmag_q};
        qs      = qneg_q ? -dvd_q : dvd_q;
        rs      = rneg_q ? -rem_q : rem_q;
        case (state_q)
            ST_IDLE: begin
                if (v_in) begin
                    n_d     = n;
                    d_d     = d;
                    sm_d    = sm;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                dvd_d   = n_neg ? -n_q : n_q;
                dmag_d  = d_neg ? -d_q : d_q;
                qneg_d  = n_neg ^ d_neg;
                rneg_d  = n_neg;
                dz_d    = d_q == 16'd0;
                rem_d   = 17'd0;
                cnt_d   = 5'd0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                rem_d   = diff[17] ? sh[16:0] : diff[16:0];
                dvd_d   = {dvd_q[30:0], ~diff[17]};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'(ITER - 1) ? ST_FIX : ST_ITER;
            end
            default: begin
                q_d     = dz_q ? 32'hFFFF_FFFF : qs;
                r_d     = dz_q ? {sm_q[1] & n_q[15], n_q[15:0]} : rs;
                div0_d  = dz_q;
                // a negative quotient may reach -2^31, a positive one only 2^31-1
                ovf_d   = ~dz_q & (sm_q != 2'b00) & (qneg_q ? dvd_q > 32'h8000_0000 : dvd_q[31]);
                v_out_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            d_q     <= '0;
            sm_q    <= '0;
            dvd_q   <= '0;
            dmag_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            v_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            sm_q    <= sm_d;
            dvd_q   <= dvd_d;
            dmag_q  <= dmag_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            v_out_q <= v_out_d;
        end
    end

    assign ready = state_q == ST_IDLE;
    assign q     = q_q;
    assign r     = r_q;
    assign div0  = div0_q;
    assign ovf   = ovf_q;
    assign v_out = v_out_q;
endmodule

// File: tb/tb_booth_div_32x16_seq.sv
// tb_booth_div_32x16_seq: scoreboard bench for the sequential divider.
module tb_booth_div_32x16_seq;
    logic        clk = 1'b0, rst = 1'b1, v_in = 1'b0;
    logic        ready, div0, ovf, v_out;
    logic [31:0] n = '0, q;
    logic [15:0] d = '0;
    logic [1:0]  sm = '0;
    logic [16:0] r;
    int          ncmp = 0, nerr = 0;

    typedef struct {
        logic [31:0] q;
        logic [16:0] r;
        logic        div0;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    booth_div_32x16_seq dut (
        .clk(clk), .rst(rst), .v_in(v_in), .ready(ready), .n(n), .d(d), .sm(sm),
        .q(q), .r(r), .div0(div0), .ovf(ovf), .v_out(v_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] nn, input logic [15:0] dd, input logic [1:0] s);
        exp_t   e;
        longint nv, dv, qt, rt;
        nv = s[1] ? {{32{nn[31]}}, nn} : {32'd0, nn};
        dv = s[0] ? {{48{dd[15]}}, dd} : {48'd0, dd};
        if (dd == 16'd0) begin
            e.q    = 32'hFFFF_FFFF;
            e.r    = {s[1] & nn[15], nn[15:0]};
            e.div0 = 1'b1;
            e.ovf  = 1'b0;
        end else begin
            qt     = nv / dv;
            rt     = nv % dv;
            e.q    = qt[31:0];
            e.r    = rt[16:0];
            e.div0 = 1'b0;
            e.ovf  = (s != 2'b00) && (qt > 64'sd2147483647 || qt < -64'sd2147483648);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (v_out) begin
            if (exp_q.size() == 0) chk("spurious_vout", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_q", q, e.q);
                chk("sb_r", r, e.r);
                chk("sb_div0", div0, e.div0);
                chk("sb_ovf", ovf, e.ovf);
            end
        end
    end

    task automatic start(input logic [31:0] nn, input logic [15:0] dd, input logic [1:0] s);
        chk("ready_at_start", ready, 1);
        n = nn;
        d = dd;
        sm = s;
        v_in = 1'b1;
        exp_q.push_back(model(nn, dd, s));
        @(posedge clk);
        #1 v_in = 1'b0;
    endtask

    task automatic wait_done(input bit chk_ready, output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1 k++;
            if (chk_ready && k < 34) chk("ready_busy", ready, 0);
        end while (!v_out && k < 40);
        if (!v_out) chk("timeout", 0, 1);
    endtask

    task automatic op_chk(input logic [31:0] nn, input logic [15:0] dd, input logic [1:0] s,
                          input logic [31:0] eq, input logic [16:0] er, input logic ed, input logic eo);
        int k;
        start(nn, dd, s);
        wait_done(1'b0, k);
        chk("latency", k, 34);
        chk("q", q, eq);
        chk("r", r, er);
        chk("div0", div0, ed);
        chk("ovf", ovf, eo);
        chk("ready_done", ready, 1);
        @(posedge clk);
        #1 chk("vout_pulse", v_out, 0);
    endtask

    initial begin
        int k;
        logic [31:0] bn[4];
        logic [15:0] bd[4];
        bn = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
        bd = '{16'h8000, 16'hFFFF, 16'h0001, 16'h0000};
        #1;
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_flags", {div0, ovf, v_out}, 0);
        chk("rst_ready", ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        start(32'd100, 16'd7, 2'b00);
        wait_done(1'b1, k);
        chk("lat_first", k, 34);
        chk("q_100_7", q, 32'd14);
        chk("r_100_7", r, 17'd2);
        chk("flags_100_7", {div0, ovf}, 0);
        @(posedge clk);
        #1 chk("vout_pulse", v_out, 0);

        op_chk(32'hFFFF_FF9C, 16'd7, 2'b11, 32'hFFFF_FFF2, 17'h1_FFFE, 1'b0, 1'b0);
        op_chk(32'd100, 16'hFFF9, 2'b11, 32'hFFFF_FFF2, 17'd2, 1'b0, 1'b0);
        op_chk(32'h1234_5678, 16'd0, 2'b00, 32'hFFFF_FFFF, 17'h0_5678, 1'b1, 1'b0);
        op_chk(32'h8000_0000, 16'hFFFF, 2'b11, 32'h8000_0000, 17'd0, 1'b0, 1'b1);
        op_chk(32'hFFFF_FFFF, 16'hFFFF, 2'b01, 32'h0000_0001, 17'd0, 1'b0, 1'b1);

        // busy strobes on edges 5 and 20, back-to-back accept on edge 35
        start(32'd100, 16'd7, 2'b00);
        for (int i = 1; i <= 34; i++) begin
            v_in = (i == 5 || i == 20);
            n = 32'd5;
            d = 16'd1;
            @(posedge clk);
            #1 v_in = 1'b0;
            if (i == 34) chk("busy_vout", v_out, 1);
        end
        chk("busy_q", q, 32'd14);
        start(32'hFFFF_FFFF, 16'hFFFF, 2'b00);
        wait_done(1'b0, k);
        chk("lat_b2b", k, 34);
        chk("q_b2b", q, 32'h0001_0001);
        chk("r_b2b", r, 17'd0);

        // abort mid-operation
        start(32'd7, 16'd2, 2'b00);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_flags", {div0, ovf, v_out}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_ready", ready, 1);
        op_chk(32'd1000, 16'd10, 2'b00, 32'd100, 17'd0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] rn;
            logic [15:0] rd;
            rn = ($urandom_range(0, 2) == 0) ? bn[$urandom_range(0, 3)] : $urandom();
            rd = ($urandom_range(0, 2) == 0) ? bd[$urandom_range(0, 3)] : 16'($urandom());
            start(rn, rd, 2'($urandom_range(0, 3)));
            wait_done(1'b0, k);
            chk("lat_rand", k, 34);
        end
        @(posedge clk);
        #1 chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
